buffer: RTL and testbench

Synchronous single-clock FIFO buffer for the SPI datapath. It holds up to DEPTH words of DWIDTH bits between a producer (write side) and a consumer (read side), and reports full and empty status. `flush` is an asynchronous active-high reset that empties the buffer.

---
 rtl/buffer.sv | 37 +++
 tb/tb_buffer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/buffer.sv
// buffer: synchronous FIFO with async flush, registered read data and pointer-derived full/empty
module buffer #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              flush,
  input  logic              buff_WEn,
  input  logic              buff_REn,
  input  logic [DWIDTH-1:0] dataIn,
  output logic [DWIDTH-1:0] dataOut,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic wr, rd;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr    = buff_WEn && !full && !flush;
  assign rd    = buff_REn && !empty;
  always_ff @(posedge i_clk or posedge flush)
    if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      dataOut <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        dataOut <= mem[rptr[AW-1:0]];
        rptr    <= rptr + 1'b1;
      end
    end
  always_ff @(posedge i_clk)
    if (wr) mem[wptr[AW-1:0]] <= dataIn;
endmodule

// File: tb/tb_buffer.sv
// tb_buffer: vector table plus reference-queue scoreboard for the buffer FIFO
module tb_buffer;
  logic i_clk = 0, flush = 1, buff_WEn = 0, buff_REn = 0;
  logic [7:0] dataIn = 0, dataOut;
  logic full, empty;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];
  logic [7:0] model_dout = 0;

  typedef struct {
    logic we, re;
    logic [7:0] din;
    logic full, empty;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[18];

  buffer #(8, 8) dut (
    .i_clk(i_clk), .flush(flush), .buff_WEn(buff_WEn), .buff_REn(buff_REn),
    .dataIn(dataIn), .dataOut(dataOut), .full(full), .empty(empty)
  );

  always #10 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one cycle and compares against the queue model.
  task automatic cycle(input logic we, input logic re, input logic [7:0] d);
    bit wa, ra;
    buff_WEn = we;
    buff_REn = re;
    dataIn = d;
    wa = we && sb.size() < 8;
    ra = re && sb.size() > 0;
    @(posedge i_clk);
    if (ra) model_dout = sb.pop_front();
    if (wa) sb.push_back(d);
    @(negedge i_clk);
    buff_WEn = 0;
    buff_REn = 0;
    check("dout", dataOut, model_dout);
    check("full", full, sb.size() == 8);
    check("empty", empty, sb.size() == 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 0, 8'h11 + 8'(i), i == 7, 0, 8'h00};
    tbl[8] = '{1, 0, 8'hAA, 1, 0, 8'h00};
    for (int i = 0; i < 8; i++) tbl[9 + i] = '{0, 1, 8'h00, 0, i == 7, 8'h11 + 8'(i)};
    tbl[17] = '{0, 1, 8'h00, 0, 1, 8'h18};

    buff_WEn = 1;
    dataIn = 8'h77;
    #44 buff_WEn = 0;
    #1 flush = 0;
    @(negedge i_clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", dataOut, 0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].din);
      check($sformatf("vec%0d_full", i), full, tbl[i].full);
      check($sformatf("vec%0d_empty", i), empty, tbl[i].empty);
      check($sformatf("vec%0d_dout", i), dataOut, tbl[i].dout);
    end

    for (int i = 0; i < 3; i++) cycle(1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    check("simul_drained", empty, 1);
    check("simul_last", dataOut, 8'h44);

    cycle(1, 1, 8'h5C);
    check("empty_rw_empty", empty, 0);
    check("empty_rw_dout", dataOut, 8'h44);
    cycle(0, 1, 0);
    check("empty_rw_read", dataOut, 8'h5C);

    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 8'(i));
      cycle(0, 1, 0);
      check("wrap_data", dataOut, 8'(i));
    end

    for (int i = 0; i < 100; i++)
      cycle(1'($urandom), 1'($urandom), 8'($urandom));

    for (int i = 0; i < 8 && sb.size() > 0; i++) cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'hC0 + 8'(i));
    #3 flush = 1;
    #2;
    check("flush_empty", empty, 1);
    check("flush_full", full, 0);
    check("flush_dout", dataOut, 0);
    sb.delete();
    model_dout = 0;
    buff_WEn = 1;
    dataIn = 8'hEE;
    @(posedge i_clk);
    #5 flush = 0;
    buff_WEn = 0;
    @(negedge i_clk);
    check("flush_edge_write", empty, 1);
    cycle(1, 0, 8'h9A);
    cycle(0, 1, 0);
    check("post_flush_read", dataOut, 8'h9A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
